// File: rtl/branch_pkg.sv
// Shared types for the decode-stage branch resolution block.
package branch_pkg;

   localparam int unsigned PC_W           = 16;
   localparam int unsigned IDX_W          = 4;
   localparam int unsigned FIFO_DEPTH_DEF = 2;
   localparam int unsigned CNT_W_DEF      = 16;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RECOVER = 1'b1
   } br_state_e;

   // One queued predictor update, head field first (MSB)
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             taken;
      logic [PC_W-1:0]  target;
      logic             mispredict;
   } upd_entry_t;

   localparam int unsigned UPD_ENTRY_W = IDX_W + 1 + PC_W + 1;

   // Wrong direction, or right (taken) direction with the wrong target
   function automatic logic is_mispredict(input logic            pred_taken,
                                          input logic [PC_W-1:0] pred_target,
                                          input logic            actual_taken,
                                          input logic [PC_W-1:0] actual_target);
      return (pred_taken != actual_taken) ||
             (actual_taken && (pred_target != actual_target));
   endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// Small synchronous FIFO holding predictor updates; push and pop may coincide when full.
module branch_update_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          do_push, do_pop;

   // Wrap bit distinguishes full from empty when the index bits match
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

   assign head_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer registers; reset drops any queued entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents are only observed while non-empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolution, misprediction recovery and predictor-update sequencing.
module branch_resolve_ctrl
   import branch_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              id_valid,
   input  logic              id_is_branch,
   input  logic [PC_W-1:0]   id_pc,
   input  logic [PC_W-1:0]   id_pc_next,
   input  logic              id_pred_taken,
   input  logic [PC_W-1:0]   id_pred_target,
   input  logic              id_actual_taken,
   input  logic [PC_W-1:0]   id_actual_target,
   input  logic              bp_wr_ready,
   output logic              stall_req,
   output logic              flush_if_id,
   output logic              redirect_valid,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              upd_valid,
   output logic [IDX_W-1:0]  upd_idx,
   output logic              upd_taken,
   output logic [PC_W-1:0]   upd_target,
   output logic              upd_mispredict,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   br_state_e              state_q, state_d;
   logic [PC_W-1:0]        redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0]       branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]       misp_cnt_q, misp_cnt_d;

   logic                   full_c, empty_c, deq_c, accept_c, mispredict_c, branch_c;
   upd_entry_t             enq_entry_c, head_c;
   logic [UPD_ENTRY_W-1:0] head_bits_c;
   logic                   unused_pc_hi_c;

   // Only the low PC bits index the predictor
   assign unused_pc_hi_c = ^id_pc[PC_W-1:IDX_W];

   assign mispredict_c = is_mispredict(id_pred_taken, id_pred_target,
                                       id_actual_taken, id_actual_target);

   // The wrong-path slot during RECOVER is never accepted
   assign branch_c  = id_valid && id_is_branch && (state_q == ST_IDLE);
   assign deq_c     = !empty_c && bp_wr_ready;
   assign accept_c  = branch_c && !stall_in && (!full_c || deq_c);
   assign stall_req = branch_c && full_c && !deq_c;

   assign enq_entry_c = '{idx:        id_pc[IDX_W-1:0],
                          taken:      id_actual_taken,
                          target:     id_actual_target,
                          mispredict: mispredict_c};

   branch_update_fifo #(
      .W     (UPD_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_upd_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept_c),
      .pop_i   (deq_c),
      .data_i  (enq_entry_c),
      .head_o  (head_bits_c),
      .full_o  (full_c),
      .empty_o (empty_c)
   );

   assign head_c = head_bits_c;

   // Present the queue head to the predictor write port; zero when empty
   always_comb begin
      upd_valid      = deq_c;
      upd_idx        = '0;
      upd_taken      = 1'b0;
      upd_target     = '0;
      upd_mispredict = 1'b0;
      if (!empty_c) begin
         upd_idx        = head_c.idx;
         upd_taken      = head_c.taken;
         upd_target     = head_c.target;
         upd_mispredict = head_c.mispredict;
      end
   end

   // Next state and redirect target; RECOVER is a single flush cycle
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c && mispredict_c) begin
               state_d       = ST_RECOVER;
               redirect_pc_d = id_actual_taken ? id_actual_target : id_pc_next;
            end
         end
         ST_RECOVER: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Saturating statistics
   always_comb begin
      branch_cnt_d = branch_cnt_q;
      misp_cnt_d   = misp_cnt_q;
      if (accept_c && (branch_cnt_q != CNT_MAX)) begin
         branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (accept_c && mispredict_c && (misp_cnt_q != CNT_MAX)) begin
         misp_cnt_d = misp_cnt_q + CNT_W'(1);
      end
   end

   // State, redirect and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         redirect_pc_q <= '0;
         branch_cnt_q  <= '0;
         misp_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         branch_cnt_q  <= branch_cnt_d;
         misp_cnt_q    <= misp_cnt_d;
      end
   end

   assign flush_if_id    = (state_q == ST_RECOVER);
   assign redirect_valid = (state_q == ST_RECOVER);
   assign redirect_pc    = redirect_pc_q;
   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = misp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed vector bench for branch_resolve_ctrl; a 2-bit-counter instance covers saturation.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in, id_valid, id_is_branch, id_pred_taken, id_actual_taken, bp_wr_ready;
   logic [15:0] id_pc, id_pc_next, id_pred_target, id_actual_target;

   logic        stall_req, flush_if_id, redirect_valid, upd_valid, upd_taken, upd_mispredict;
   logic [15:0] redirect_pc, upd_target, branch_cnt, mispredict_cnt;
   logic [3:0]  upd_idx;

   logic        s_stall_req, s_flush, s_rv, s_uv, s_ut, s_um;
   logic [15:0] s_rpc, s_utgt;
   logic [3:0]  s_uidx;
   logic [1:0]  s_bcnt, s_mcnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .id_valid(id_valid),
      .id_is_branch(id_is_branch), .id_pc(id_pc), .id_pc_next(id_pc_next),
      .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
      .id_actual_taken(id_actual_taken), .id_actual_target(id_actual_target),
      .bp_wr_ready(bp_wr_ready), .stall_req(stall_req), .flush_if_id(flush_if_id),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
      .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   // Counter max is 3 here, so two branches put it one below saturation
   branch_resolve_ctrl #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .stall_in(stall_in), .id_valid(id_valid),
      .id_is_branch(id_is_branch), .id_pc(id_pc), .id_pc_next(id_pc_next),
      .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
      .id_actual_taken(id_actual_taken), .id_actual_target(id_actual_target),
      .bp_wr_ready(bp_wr_ready), .stall_req(s_stall_req), .flush_if_id(s_flush),
      .redirect_valid(s_rv), .redirect_pc(s_rpc), .upd_valid(s_uv),
      .upd_idx(s_uidx), .upd_taken(s_ut), .upd_target(s_utgt),
      .upd_mispredict(s_um), .branch_cnt(s_bcnt), .mispredict_cnt(s_mcnt)
   );

   typedef struct packed {
      logic        stall, valid, br;
      logic [15:0] pc;
      logic        pt;
      logic [15:0] ptg;
      logic        at;
      logic [15:0] atg;
      logic        rdy;
   } in_t;

   typedef struct packed {
      logic        stall_req, flush, rv;
      logic [15:0] rpc;
      logic        uv;
      logic [3:0]  uidx;
      logic        ut;
      logic [15:0] utgt;
      logic        um;
      logic [15:0] bcnt, mcnt;
      logic [1:0]  sbcnt, smcnt;
   } exp_t;

   typedef struct {
      in_t  vin;
      exp_t vexp;
   } vec_t;

   vec_t vq[$];

   function automatic in_t idle(input logic rdy);
      in_t x = '0;
      x.rdy = rdy;
      return x;
   endfunction

   function automatic in_t br(input logic [15:0] pc, input logic pt, input logic [15:0] ptg,
                              input logic at, input logic [15:0] atg, input logic rdy);
      in_t x;
      x.stall = 1'b0; x.valid = 1'b1; x.br = 1'b1;
      x.pc = pc; x.pt = pt; x.ptg = ptg; x.at = at; x.atg = atg; x.rdy = rdy;
      return x;
   endfunction

   function automatic in_t stl(input in_t x);
      in_t y = x;
      y.stall = 1'b1;
      return y;
   endfunction

   function automatic in_t nov(input in_t x);
      in_t y = x;
      y.valid = 1'b0;
      return y;
   endfunction

   function automatic in_t nob(input in_t x);
      in_t y = x;
      y.br = 1'b0;
      return y;
   endfunction

   // Redirect valid always tracks flush; 2-bit counts are the 16-bit counts clamped at 3
   function automatic exp_t ex(input logic s, input logic f, input logic [15:0] rpc,
                               input logic uv, input logic [3:0] ui, input logic ut,
                               input logic [15:0] utg, input logic um,
                               input int unsigned bc, input int unsigned mc);
      exp_t e;
      e.stall_req = s; e.flush = f; e.rv = f; e.rpc = rpc;
      e.uv = uv; e.uidx = ui; e.ut = ut; e.utgt = utg; e.um = um;
      e.bcnt  = 16'(bc);
      e.mcnt  = 16'(mc);
      e.sbcnt = (bc > 3) ? 2'd3 : 2'(bc);
      e.smcnt = (mc > 3) ? 2'd3 : 2'(mc);
      return e;
   endfunction

   function automatic exp_t zc(input int unsigned bc, input int unsigned mc);
      return ex(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, bc, mc);
   endfunction

   task automatic add(input in_t a, input exp_t b);
      vec_t v;
      v.vin  = a;
      v.vexp = b;
      vq.push_back(v);
   endtask

   task automatic drive(input in_t x);
      stall_in         = x.stall;
      id_valid         = x.valid;
      id_is_branch     = x.br;
      id_pc            = x.pc;
      id_pc_next       = x.pc + 16'd2;
      id_pred_taken    = x.pt;
      id_pred_target   = x.ptg;
      id_actual_taken  = x.at;
      id_actual_target = x.atg;
      bp_wr_ready      = x.rdy;
   endtask

   task automatic check(input string name, input exp_t e);
      exp_t a;
      a.stall_req = stall_req; a.flush = flush_if_id; a.rv = redirect_valid;
      a.rpc = redirect_pc; a.uv = upd_valid; a.uidx = upd_idx; a.ut = upd_taken;
      a.utgt = upd_target; a.um = upd_mispredict; a.bcnt = branch_cnt;
      a.mcnt = mispredict_cnt; a.sbcnt = s_bcnt; a.smcnt = s_mcnt;
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h want %h (stall,flush,rv,rpc,uv,idx,tk,tgt,mp,bcnt,mcnt,sb,sm)",
                  name, a, e);
      end
   endtask

   initial begin
      drive(idle(1'b0));
      #2 check("reset_state", zc(0, 0));
      @(negedge clk) rst = 1'b0;

      // Correctly predicted taken branch
      add(idle(1),                                  zc(0, 0));
      add(br(16'h0010, 1, 16'h0040, 1, 16'h0040, 1), zc(0, 0));
      add(idle(1), ex(0, 0, 16'h0, 1, 4'h0, 1, 16'h0040, 0, 1, 0));
      // Predicted NT, actual T; a wrong-path branch follows
      add(br(16'h0012, 0, 16'h0014, 1, 16'h0080, 1), zc(1, 0));
      add(br(16'h0030, 1, 16'h0050, 0, 16'h0050, 1), ex(0, 1, 16'h0080, 1, 4'h2, 1, 16'h0080, 1, 2, 1));
      add(idle(1),                                  zc(2, 1));
      // Predicted T, actual NT: redirect to fall-through
      add(br(16'h0020, 1, 16'h0060, 0, 16'h0060, 1), zc(2, 1));
      add(br(16'h0022, 0, 16'h0022, 1, 16'h0100, 1), ex(0, 1, 16'h0022, 1, 4'h0, 0, 16'h0060, 1, 3, 2));
      add(idle(1),                                  zc(3, 2));
      // Right direction, wrong target
      add(br(16'h0034, 1, 16'h0040, 1, 16'h0044, 1), zc(3, 2));
      add(idle(1), ex(0, 1, 16'h0044, 1, 4'h4, 1, 16'h0044, 1, 4, 3));
      add(idle(1),                                  zc(4, 3));
      // Both not-taken with differing targets is not a mispredict
      add(br(16'h0046, 0, 16'h1234, 0, 16'h0048, 1), zc(4, 3));
      add(idle(1), ex(0, 0, 16'h0, 1, 4'h6, 0, 16'h0048, 0, 5, 3));
      // Stalled, invalid and non-branch slots are ignored
      add(stl(br(16'h0050, 0, 16'h0, 1, 16'h0300, 1)), zc(5, 3));
      add(idle(1),                                     zc(5, 3));
      add(nov(br(16'h0052, 0, 16'h0, 1, 16'h0300, 1)), zc(5, 3));
      add(idle(1),                                     zc(5, 3));
      add(nob(br(16'h0054, 0, 16'h0, 1, 16'h0300, 1)), zc(5, 3));
      add(idle(1),                                     zc(5, 3));
      // Write port busy: two queue, third stalls until the port frees
      add(br(16'h0061, 1, 16'h0070, 1, 16'h0070, 0), zc(5, 3));
      add(br(16'h0063, 0, 16'h0065, 0, 16'h0065, 0), ex(0, 0, 16'h0, 0, 4'h1, 1, 16'h0070, 0, 6, 3));
      add(br(16'h0065, 1, 16'h0090, 1, 16'h0090, 0), ex(1, 0, 16'h0, 0, 4'h1, 1, 16'h0070, 0, 7, 3));
      add(br(16'h0065, 1, 16'h0090, 1, 16'h0090, 0), ex(1, 0, 16'h0, 0, 4'h1, 1, 16'h0070, 0, 7, 3));
      add(br(16'h0065, 1, 16'h0090, 1, 16'h0090, 1), ex(0, 0, 16'h0, 1, 4'h1, 1, 16'h0070, 0, 7, 3));
      add(idle(0), ex(0, 0, 16'h0, 0, 4'h3, 0, 16'h0065, 0, 8, 3));
      add(idle(1), ex(0, 0, 16'h0, 1, 4'h3, 0, 16'h0065, 0, 8, 3));
      add(idle(1), ex(0, 0, 16'h0, 1, 4'h5, 1, 16'h0090, 0, 8, 3));
      add(idle(1), zc(8, 3));
      // Mispredict accepted while full with a same-cycle drain; no stall during RECOVER
      add(br(16'h0070, 1, 16'h0072, 1, 16'h0072, 0), zc(8, 3));
      add(br(16'h0072, 0, 16'h0074, 0, 16'h0074, 0), ex(0, 0, 16'h0, 0, 4'h0, 1, 16'h0072, 0, 9, 3));
      add(br(16'h0078, 0, 16'h0078, 1, 16'h0200, 1), ex(0, 0, 16'h0, 1, 4'h0, 1, 16'h0072, 0, 10, 3));
      add(br(16'h007A, 1, 16'h0080, 0, 16'h0080, 0), ex(0, 1, 16'h0200, 0, 4'h2, 0, 16'h0074, 0, 11, 4));
      add(idle(1), ex(0, 0, 16'h0, 1, 4'h2, 0, 16'h0074, 0, 11, 4));
      add(idle(1), ex(0, 0, 16'h0, 1, 4'h8, 1, 16'h0200, 1, 11, 4));
      add(idle(1), zc(11, 4));

      foreach (vq[k]) begin
         @(negedge clk);
         drive(vq[k].vin);
         #2 check($sformatf("vec%0d", k), vq[k].vexp);
      end

      // Async reset in the middle of RECOVER with two queued entries
      @(negedge clk) drive(br(16'h0010, 1, 16'h0040, 1, 16'h0040, 0));
      @(negedge clk) drive(br(16'h0012, 0, 16'h0014, 1, 16'h0080, 0));
      @(negedge clk) drive(idle(1'b0));
      #2 check("pre_reset", ex(0, 1, 16'h0080, 0, 4'h0, 1, 16'h0040, 0, 13, 5));
      rst = 1'b1;
      #1 check("async_reset", zc(0, 0));
      @(negedge clk);
      rst = 1'b0;
      drive(idle(1'b1));
      #2 check("post_reset", zc(0, 0));
      @(negedge clk) drive(br(16'h0015, 1, 16'h0040, 1, 16'h0040, 1));
      #2 check("post_reset_idle", zc(0, 0));
      @(negedge clk) drive(idle(1'b1));
      #2 check("post_reset_branch", ex(0, 0, 16'h0, 1, 4'h5, 1, 16'h0040, 0, 1, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
